// File: rtl/mem_pkg.sv
// mem_pkg: shared types and defaults for the external memory port arbiter.
//   - arb_state_e : arbiter FSM states
//   - *_DEF       : default widths / timeout
//   - cnt_width() : width of the timeout counter for a given TIMEOUT
package mem_pkg;

   localparam int ADDR_W_DEF  = 16;
   localparam int DATA_W_DEF  = 32;
   localparam int TIMEOUT_DEF = 255;
   localparam int CNT_W_DEF   = $clog2(TIMEOUT_DEF + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } arb_state_e;

   // Counter must be able to hold the value TIMEOUT itself.
   function automatic int cnt_width(input int timeout);
      return (timeout < 1) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester and external-memory signals of the arbiter.
//   slave  : arbiter side (takes IF/MEM requests, drives ext_mem_* commands)
//   master : environment side (requesters + memory model)
interface mem_port_arbiter_if
   import mem_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);
   // instruction-fetch requester
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_ack;
   // MEM-stage data requester
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_ack;
   // external memory
   logic [ADDR_W-1:0] ext_mem_addr;
   logic [DATA_W-1:0] ext_mem_wdata;
   logic              ext_mem_write;
   logic              ext_mem_read;
   logic [DATA_W-1:0] ext_mem_rdata;
   logic              ext_mem_ready;
   // status
   logic              stall;
   logic              timeout_err;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, ext_mem_rdata, ext_mem_ready,
      output if_rdata, if_ack, d_rdata, d_ack, ext_mem_addr, ext_mem_wdata,
             ext_mem_write, ext_mem_read, stall, timeout_err
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, ext_mem_rdata, ext_mem_ready,
      input  if_rdata, if_ack, d_rdata, d_ack, ext_mem_addr, ext_mem_wdata,
             ext_mem_write, ext_mem_read, stall, timeout_err
   );

endinterface

// File: rtl/mem_timeout_cnt.sv
// mem_timeout_cnt: clearable saturating up-counter.
//   clk, rst : clock, async active-low reset
//   clr      : load zero (wins over en)
//   en       : count up by one, saturating at all-ones
//   hit      : counter value equals LIMIT
module mem_timeout_cnt #(
   parameter int CNT_W = 8,
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic hit
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (en && (cnt_q != {CNT_W{1'b1}}))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   assign hit = (cnt_q == CNT_W'(LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one external memory port between instruction fetch
// and the MEM-stage data requester, one word transaction at a time.
//   clk, rst : clock, async active-low reset
//   bus      : slave side of mem_port_arbiter_if
//              if_*      fetch request / ack / read data
//              d_*       load/store request / ack / read data
//              ext_mem_* registered memory command, rdata/ready from memory
//              stall     d_req & ~d_ack
//              timeout_err sticky, set when a transaction is aborted
// Commands are registered: a request sampled in IDLE shows on ext_mem_* the
// next cycle; ready sampled in a busy cycle produces the ack one cycle later.
module mem_port_arbiter
   import mem_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   mem_port_arbiter_if.slave bus
);

   localparam int CNT_W = cnt_width(TIMEOUT);

   arb_state_e        state_q, state_d;
   logic              last_d_q, last_d_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              rd_q, rd_d, wr_q, wr_d;
   logic              if_ack_q, if_ack_d, d_ack_q, d_ack_d;
   logic              terr_q, terr_d;
   logic              grant, busy, hit, ack_gap, pick_d;

   assign busy    = (state_q == BUSY_I) || (state_q == BUSY_D);
   // The ack cycle is spent in IDLE without granting, so a requester that
   // still holds req while its ack is on the wire is not served twice.
   assign ack_gap = if_ack_q | d_ack_q;
   // Tie goes to whoever was not served last.
   assign pick_d  = bus.d_req & (~bus.if_req | ~last_d_q);

   always_comb begin
      state_d    = state_q;
      last_d_d   = last_d_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      rd_d       = rd_q;
      wr_d       = wr_q;
      terr_d     = terr_q;
      if_ack_d   = 1'b0;
      d_ack_d    = 1'b0;
      grant      = 1'b0;
      case (state_q)
         IDLE: begin
            if (!ack_gap && (bus.d_req || bus.if_req)) begin
               grant = 1'b1;
               if (pick_d) begin
                  state_d = BUSY_D;
                  addr_d  = bus.d_addr;
                  wdata_d = bus.d_wdata;
                  rd_d    = ~bus.d_we;
                  wr_d    = bus.d_we;
               end else begin
                  state_d = BUSY_I;
                  addr_d  = bus.if_addr;
                  rd_d    = 1'b1;
                  wr_d    = 1'b0;
               end
            end
         end
         BUSY_I, BUSY_D: begin
            // Ready wins over a simultaneous timeout hit.
            if (bus.ext_mem_ready || hit) begin
               state_d  = IDLE;
               rd_d     = 1'b0;
               wr_d     = 1'b0;
               last_d_d = (state_q == BUSY_D);
               if (!bus.ext_mem_ready) terr_d = 1'b1;
               if (state_q == BUSY_D) begin
                  d_ack_d = 1'b1;
                  if (!bus.ext_mem_ready) d_rdata_d = '0;
                  else if (!wr_q)         d_rdata_d = bus.ext_mem_rdata;
               end else begin
                  if_ack_d   = 1'b1;
                  if_rdata_d = bus.ext_mem_ready ? bus.ext_mem_rdata : '0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         last_d_q   <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
         if_ack_q   <= 1'b0;
         d_ack_q    <= 1'b0;
         terr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_d_q   <= last_d_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
         rd_q       <= rd_d;
         wr_q       <= wr_d;
         if_ack_q   <= if_ack_d;
         d_ack_q    <= d_ack_d;
         terr_q     <= terr_d;
      end
   end

   mem_timeout_cnt #(
      .CNT_W (CNT_W),
      .LIMIT (TIMEOUT)
   ) u_timeout_cnt (
      .clk (clk),
      .rst (rst),
      .clr (grant),
      .en  (busy),
      .hit (hit)
   );

   assign bus.ext_mem_addr  = addr_q;
   assign bus.ext_mem_wdata = wdata_q;
   assign bus.ext_mem_read  = rd_q;
   assign bus.ext_mem_write = wr_q;
   assign bus.if_rdata      = if_rdata_q;
   assign bus.if_ack        = if_ack_q;
   assign bus.d_rdata       = d_rdata_q;
   assign bus.d_ack         = d_ack_q;
   assign bus.timeout_err   = terr_q;
   assign bus.stall         = bus.d_req & ~d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
   localparam int AW = 16;
   localparam int DW = 32;
   localparam int TO = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
      return (a == 16'h0010) ? 32'hDEADBEEF : {~a, a};
   endfunction

   // Memory responder: ready after mem_wait wait states of an active command.
   int mem_wait = 0;
   int busy_cnt = 0;
   initial forever begin
      @(posedge clk);
      #2;
      if (bus.ext_mem_read || bus.ext_mem_write) busy_cnt++;
      else busy_cnt = 0;
      bus.ext_mem_ready = (bus.ext_mem_read || bus.ext_mem_write) && (busy_cnt > mem_wait);
      bus.ext_mem_rdata = mem_val(bus.ext_mem_addr);
   end

   // Transaction-level reference: one open transaction record, the cycle its
   // command became visible, and the cycle its ack is due.
   longint          cyc;
   longint          t_issue, ack_at;
   bit              t_act, t_d, t_we, ack_d, served_d, m_terr;
   logic [AW-1:0]   t_addr;
   logic [DW-1:0]   t_wdata, m_if_rdata, m_d_rdata;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         cyc <= 0; t_issue <= 0; ack_at <= -1;
         t_act <= 0; t_d <= 0; t_we <= 0; ack_d <= 0; served_d <= 0; m_terr <= 0;
         t_addr <= '0; t_wdata <= '0; m_if_rdata <= '0; m_d_rdata <= '0;
      end else begin
         cyc <= cyc + 1;
         if (t_act) begin
            if (bus.ext_mem_ready || (cyc - t_issue == TO)) begin
               t_act    <= 0;
               ack_at   <= cyc + 1;
               ack_d    <= t_d;
               served_d <= t_d;
               if (!bus.ext_mem_ready) m_terr <= 1;
               if (t_d) begin
                  if (!bus.ext_mem_ready) m_d_rdata <= '0;
                  else if (!t_we)         m_d_rdata <= bus.ext_mem_rdata;
               end else begin
                  m_if_rdata <= bus.ext_mem_ready ? bus.ext_mem_rdata : '0;
               end
            end
         end else if (cyc > ack_at && (bus.d_req || bus.if_req)) begin
            t_act   <= 1;
            t_issue <= cyc + 1;
            if (bus.d_req && (!bus.if_req || !served_d)) begin
               t_d <= 1; t_we <= bus.d_we; t_addr <= bus.d_addr; t_wdata <= bus.d_wdata;
            end else begin
               t_d <= 0; t_we <= 0; t_addr <= bus.if_addr;
            end
         end
      end
   end

   // Per-cycle compare against the reference.
   always @(negedge clk) begin
      logic e_if_ack, e_d_ack;
      e_if_ack = (cyc == ack_at) && !ack_d;
      e_d_ack  = (cyc == ack_at) && ack_d;
      chk("m_read",     bus.ext_mem_read,  t_act & ~(t_d & t_we));
      chk("m_write",    bus.ext_mem_write, t_act & t_d & t_we);
      chk("m_rw_excl",  bus.ext_mem_read & bus.ext_mem_write, 1'b0);
      chk("m_addr",     bus.ext_mem_addr,  t_addr);
      chk("m_wdata",    bus.ext_mem_wdata, t_wdata);
      chk("m_if_ack",   bus.if_ack,        e_if_ack);
      chk("m_d_ack",    bus.d_ack,         e_d_ack);
      chk("m_if_rdata", bus.if_rdata,      m_if_rdata);
      chk("m_d_rdata",  bus.d_rdata,       m_d_rdata);
      chk("m_terr",     bus.timeout_err,   m_terr);
      chk("m_stall",    bus.stall,         bus.d_req & ~e_d_ack);
   end

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0;
      bus.d_addr = '0; bus.d_wdata = '0; bus.ext_mem_ready = 0; bus.ext_mem_rdata = '0;
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_read",  bus.ext_mem_read, 1'b0);
      chk("rst_addr",  bus.ext_mem_addr, 16'h0000);
      chk("rst_d_ack", bus.d_ack, 1'b0);
      chk("rst_terr",  bus.timeout_err, 1'b0);
      chk("rst_rdata", bus.if_rdata, 32'h0);

      // Tie straight after reset: D, I, D, I with acks at 2, 5, 8, 11.
      adv();
      rst = 1'b1;
      mem_wait = 0;
      bus.if_req = 1; bus.d_req = 1; bus.d_we = 0;
      bus.if_addr = 16'h0100; bus.d_addr = 16'h0200;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         chk("tie_d_ack",  bus.d_ack,  (c == 2) || (c == 8));
         chk("tie_if_ack", bus.if_ack, (c == 5) || (c == 11));
         if (c == 1) chk("tie_addr_d", bus.ext_mem_addr, 16'h0200);
         if (c == 4) chk("tie_addr_i", bus.ext_mem_addr, 16'h0100);
         adv();
      end
      bus.if_req = 0; bus.d_req = 0;
      adv(); adv();

      // Single zero-wait load.
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 16'h0010;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("ld_stall", bus.stall, c < 2);
         chk("ld_read",  bus.ext_mem_read, c == 1);
         chk("ld_ack",   bus.d_ack, c == 2);
         if (c == 2) chk("ld_rdata", bus.d_rdata, 32'hDEADBEEF);
         adv();
      end
      bus.d_req = 0;
      adv();

      // Store with 3 wait states; d_rdata must keep the load value.
      mem_wait = 3;
      bus.d_req = 1; bus.d_we = 1; bus.d_addr = 16'h0004; bus.d_wdata = 32'h12345678;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("st_write", bus.ext_mem_write, (c >= 1) && (c <= 4));
         chk("st_ack",   bus.d_ack, c == 5);
         if (c >= 1) chk("st_wdata", bus.ext_mem_wdata, 32'h12345678);
         if (c == 5) chk("st_rdata_keep", bus.d_rdata, 32'hDEADBEEF);
         adv();
      end
      bus.d_req = 0; bus.d_we = 0;
      adv();

      // Ready in the same cycle the timeout limit is reached: ready wins.
      mem_wait = 4;
      bus.if_req = 1; bus.if_addr = 16'h0033;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         chk("edge_if_ack", bus.if_ack, c == 6);
         if (c == 6) chk("edge_rdata", bus.if_rdata, 32'hFFCC0033);
         chk("edge_terr", bus.timeout_err, 1'b0);
         adv();
      end
      bus.if_req = 0;
      adv();

      // Timeout abort on fetch.
      mem_wait = 1000;
      bus.if_req = 1; bus.if_addr = 16'h0040;
      for (int c = 0; c < 9; c++) begin
         if (c == 7) bus.if_req = 0;
         @(negedge clk);
         chk("to_read",   bus.ext_mem_read, (c >= 1) && (c <= 5));
         chk("to_if_ack", bus.if_ack, c == 6);
         chk("to_terr",   bus.timeout_err, c >= 6);
         if (c == 6) chk("to_rdata", bus.if_rdata, 32'h0);
         adv();
      end

      // Data request raised while a fetch is in flight.
      mem_wait = 2;
      bus.if_req = 1; bus.if_addr = 16'h0050;
      for (int c = 0; c < 9; c++) begin
         if (c == 1) begin bus.d_req = 1; bus.d_we = 0; bus.d_addr = 16'h0060; end
         if (c == 4) mem_wait = 0;
         if (c == 5) bus.if_req = 0;
         if (c == 8) bus.d_req = 0;
         @(negedge clk);
         chk("bz_if_ack", bus.if_ack, c == 4);
         chk("bz_d_ack",  bus.d_ack, c == 7);
         chk("bz_stall",  bus.stall, (c >= 1) && (c <= 6));
         if (c == 7) chk("bz_rdata", bus.d_rdata, 32'hFF9F0060);
         adv();
      end
      adv();

      // Reset in the middle of a data wait, then a fresh fetch.
      mem_wait = 1000;
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 16'h0070;
      for (int c = 0; c < 8; c++) begin
         if (c == 3) begin #2; rst = 1'b0; end
         if (c == 4) begin
            rst = 1'b1; bus.d_req = 0; mem_wait = 0;
            bus.if_req = 1; bus.if_addr = 16'h0080;
         end
         if (c == 7) bus.if_req = 0;
         @(negedge clk);
         chk("rm_read",   bus.ext_mem_read, (c == 1) || (c == 2) || (c == 5));
         chk("rm_d_ack",  bus.d_ack, 1'b0);
         chk("rm_if_ack", bus.if_ack, c == 6);
         if (c == 3) chk("rm_terr", bus.timeout_err, 1'b0);
         if (c == 6) chk("rm_rdata", bus.if_rdata, 32'hFF7F0080);
         adv();
      end
      adv(); adv();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
